// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared states, default geometry and address split for cache_dm
package cache_pkg;

    localparam int DEF_LINE_ADDR_LEN = 3;
    localparam int DEF_SET_ADDR_LEN  = 2;
    localparam int DEF_TAG_ADDR_LEN  = 6;
    localparam int DEF_MEM_ADDR_LEN  = DEF_TAG_ADDR_LEN + DEF_SET_ADDR_LEN + DEF_LINE_ADDR_LEN;

    typedef enum logic [1:0] {
        IDLE,
        SWAP_OUT,
        SWAP_IN,
        SWAP_IN_OK
    } cache_state_t;

    typedef struct packed {
        logic [DEF_TAG_ADDR_LEN-1:0]  tag;
        logic [DEF_SET_ADDR_LEN-1:0]  idx;
        logic [DEF_LINE_ADDR_LEN-1:0] off;
    } addr_fields_t;

    // Byte address -> {tag, set, word offset}; bits [1:0] and above the tag are ignored.
    function automatic addr_fields_t split_addr(input logic [31:0] byte_addr);
        addr_fields_t f;
        f.off = byte_addr[2 +: DEF_LINE_ADDR_LEN];
        f.idx = byte_addr[2 + DEF_LINE_ADDR_LEN +: DEF_SET_ADDR_LEN];
        f.tag = byte_addr[2 + DEF_LINE_ADDR_LEN + DEF_SET_ADDR_LEN +: DEF_TAG_ADDR_LEN];
        return f;
    endfunction

endpackage

// File: rtl/cache_dm_if.sv
// rtl/cache_dm_if.sv - CPU-side and memory-side signal bundle for cache_dm
interface cache_dm_if #(
    parameter int MEM_ADDR_LEN = 11
);
    logic                    rd_req;
    logic                    wr_req;
    logic [31:0]             addr;
    logic [31:0]             wr_data;
    logic [31:0]             rd_data;
    logic                    miss;
    logic [MEM_ADDR_LEN-1:0] mem_addr;
    logic [31:0]             mem_rd_data;
    logic                    mem_wr_req;
    logic [31:0]             mem_wr_data;

    // CPU plus memory model side
    modport master (
        output rd_req, wr_req, addr, wr_data, mem_rd_data,
        input  rd_data, miss, mem_addr, mem_wr_req, mem_wr_data
    );

    // Cache side
    modport slave (
        input  rd_req, wr_req, addr, wr_data, mem_rd_data,
        output rd_data, miss, mem_addr, mem_wr_req, mem_wr_data
    );
endinterface

// File: rtl/cache_data_array.sv
// rtl/cache_data_array.sv - line data, tag, valid and dirty storage for cache_dm
module cache_data_array #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 2,
    parameter int TAG_ADDR_LEN  = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SET_ADDR_LEN-1:0]  idx,
    input  logic [LINE_ADDR_LEN-1:0] rd_off,
    output logic [31:0]              rd_word,
    output logic [TAG_ADDR_LEN-1:0]  rd_tag,
    output logic                     rd_valid,
    output logic                     rd_dirty,
    input  logic                     wr_en,
    input  logic [LINE_ADDR_LEN-1:0] wr_off,
    input  logic [31:0]              wr_word,
    input  logic                     set_dirty,
    input  logic                     fill_done,
    input  logic [TAG_ADDR_LEN-1:0]  fill_tag
);
    localparam int SETS  = 1 << SET_ADDR_LEN;
    localparam int WORDS = 1 << LINE_ADDR_LEN;

    logic [31:0]             data_q [SETS][WORDS];
    logic [31:0]             data_d [SETS][WORDS];
    logic [TAG_ADDR_LEN-1:0] tag_q  [SETS];
    logic [TAG_ADDR_LEN-1:0] tag_d  [SETS];
    logic [SETS-1:0]         valid_q, valid_d;
    logic [SETS-1:0]         dirty_q, dirty_d;

    assign rd_word  = data_q[idx][rd_off];
    assign rd_tag   = tag_q[idx];
    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];

    // Single write port: data word, dirty mark, or line-fill completion on the selected set
    always_comb begin
        data_d  = data_q;
        tag_d   = tag_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (wr_en) begin
            data_d[idx][wr_off] = wr_word;
        end
        if (set_dirty) begin
            dirty_d[idx] = 1'b1;
        end
        if (fill_done) begin
            tag_d[idx]   = fill_tag;
            valid_d[idx] = 1'b1;
            dirty_d[idx] = 1'b0;
        end
    end

    // Status bits are reset so the cache starts empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Data and tags are qualified by valid, so they need no reset
    always_ff @(posedge clk) begin
        data_q <= data_d;
        tag_q  <= tag_d;
    end
endmodule

// File: rtl/cache_dm.sv
// rtl/cache_dm.sv - direct-mapped write-back write-allocate data cache; CACHE_STATS_EN adds access/miss counters
module cache_dm
    import cache_pkg::*;
#(
    parameter int LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
    parameter int SET_ADDR_LEN  = DEF_SET_ADDR_LEN,
    parameter int TAG_ADDR_LEN  = DEF_TAG_ADDR_LEN,
    parameter int MEM_ADDR_LEN  = DEF_MEM_ADDR_LEN
) (
    input  logic        clk,
    input  logic        rst,
    cache_dm_if.slave   bus
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] access_cnt,
    output logic [31:0] miss_cnt
`endif
);
    localparam int CNT_W = LINE_ADDR_LEN + 1;
    localparam int WORDS = 1 << LINE_ADDR_LEN;

    cache_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    addr_fields_t f;
    logic req, hit;

    logic [LINE_ADDR_LEN-1:0] rd_off, wr_off;
    logic [31:0]              rd_word, wr_word;
    logic [TAG_ADDR_LEN-1:0]  rd_tag;
    logic                     rd_valid, rd_dirty;
    logic                     wr_en, set_dirty, fill_done;

    logic                    miss_o;
    logic [31:0]             rd_data_o;
    logic [MEM_ADDR_LEN-1:0] mem_addr_o;
    logic                    mem_wr_req_o;
    logic [31:0]             mem_wr_data_o;

    assign f   = split_addr(bus.addr);
    assign req = bus.rd_req | bus.wr_req;
    assign hit = rd_valid && (rd_tag == f.tag);

    assign bus.miss        = miss_o;
    assign bus.rd_data     = rd_data_o;
    assign bus.mem_addr    = mem_addr_o;
    assign bus.mem_wr_req  = mem_wr_req_o;
    assign bus.mem_wr_data = mem_wr_data_o;

    cache_data_array #(
        .LINE_ADDR_LEN (LINE_ADDR_LEN),
        .SET_ADDR_LEN  (SET_ADDR_LEN),
        .TAG_ADDR_LEN  (TAG_ADDR_LEN)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .idx       (f.idx),
        .rd_off    (rd_off),
        .rd_word   (rd_word),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .wr_en     (wr_en),
        .wr_off    (wr_off),
        .wr_word   (wr_word),
        .set_dirty (set_dirty),
        .fill_done (fill_done),
        .fill_tag  (f.tag)
    );

    // FSM register and word counter; reset abandons any miss in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, array port steering and bus outputs
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        miss_o        = 1'b0;
        rd_data_o     = '0;
        mem_addr_o    = '0;
        mem_wr_req_o  = 1'b0;
        mem_wr_data_o = '0;
        rd_off        = f.off;
        wr_en         = 1'b0;
        wr_off        = f.off;
        wr_word       = bus.wr_data;
        set_dirty     = 1'b0;
        fill_done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    miss_o  = 1'b1;
                    cnt_d   = '0;
                    state_d = (rd_valid && rd_dirty) ? SWAP_OUT : SWAP_IN;
                end else if (req) begin
                    if (bus.wr_req) begin
                        wr_en     = 1'b1;
                        set_dirty = 1'b1;
                    end
                    if (bus.rd_req) begin
                        rd_data_o = rd_word;
                    end
                end
            end
            SWAP_OUT: begin
                miss_o        = 1'b1;
                rd_off        = cnt_q[LINE_ADDR_LEN-1:0];
                mem_wr_req_o  = 1'b1;
                mem_addr_o    = {rd_tag, f.idx, cnt_q[LINE_ADDR_LEN-1:0]};
                mem_wr_data_o = rd_word;
                if (cnt_q == CNT_W'(WORDS - 1)) begin
                    cnt_d   = '0;
                    state_d = SWAP_IN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SWAP_IN: begin
                // Word i is issued at count i and lands one count later
                miss_o     = 1'b1;
                mem_addr_o = {f.tag, f.idx, cnt_q[LINE_ADDR_LEN-1:0]};
                if (cnt_q != '0) begin
                    wr_en   = 1'b1;
                    wr_off  = cnt_q[LINE_ADDR_LEN-1:0] - 1'b1;
                    wr_word = bus.mem_rd_data;
                end
                if (cnt_q == CNT_W'(WORDS)) begin
                    cnt_d   = '0;
                    state_d = SWAP_IN_OK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SWAP_IN_OK: begin
                miss_o    = 1'b1;
                fill_done = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef CACHE_STATS_EN
    logic [31:0] access_cnt_q, access_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic        start_miss;

    assign start_miss = (state_q == IDLE) && req && !hit;
    assign access_cnt = access_cnt_q;
    assign miss_cnt   = miss_cnt_q;

    // Completed accesses and miss entries
    always_comb begin
        access_cnt_d = access_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (req && !miss_o) begin
            access_cnt_d = access_cnt_q + 32'd1;
        end
        if (start_miss) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            access_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            access_cnt_q <= access_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end
`endif
endmodule
